// File: rtl/eth_pkg.sv
// Shared types and constants for the MII transmit path: FSM states, preamble/SFD
// nibbles, CRC-32 parameters and a one-nibble reflected CRC step.
package eth_pkg;
   typedef enum logic [2:0] {
      ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG
   } state_t;

   localparam logic [3:0]  PRE_NIB   = 4'h5;
   localparam logic [3:0]  SFD_NIB   = 4'hD;
   localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
   localparam int          MIN_FRAME = 60;
   localparam int          MAX_FRAME = 1514;
   localparam int          PRE_LEN   = 15;

   // Bit 0 of the nibble is the first bit on the wire, hence the LSB-first loop.
   function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
      logic [31:0] c;
      c = crc ^ {28'd0, nib};
      for (int i = 0; i < 4; i++)
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      return c;
   endfunction
endpackage

// File: rtl/eth_crc32.sv
// Registered Ethernet CRC-32 accumulator, advanced one nibble per enable.
module eth_crc32
   import eth_pkg::*;
(
   input  logic        mainclk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [3:0]  nib,
   output logic [31:0] crc
);
   logic [31:0] crc_reg;

   always_ff @(posedge mainclk) begin
      if (rst || init)
         crc_reg <= CRC_INIT;
      else if (en)
         crc_reg <= crc_nibble(crc_reg, nib);
   end

   assign crc = crc_reg;
endmodule

// File: rtl/eth_mii_tx.sv
// Streams a RAM-resident frame onto MII: preamble, SFD, payload, optional zero pad,
// FCS and inter-frame gap, one nibble per tick recovered from the PHY TX clock.
module eth_mii_tx
   import eth_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int IFG_NIB = 24,
   parameter int PAD_EN  = 1
) (
   input  logic              mainclk,
   input  logic              rst,
   input  logic              eth_tx_clk,
   input  logic              start,
   input  logic [10:0]       frame_len,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              ready,
   output logic              done,
   output logic              len_err,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic              eth_tx_en,
   output logic [3:0]        eth_txd
);
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_t            state_reg, state_next;
   logic [11:0]       cnt_reg, cnt_next;
   logic [10:0]       len_reg, len_next;
   logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
   logic [31:0]       cur_word_reg, next_word_reg;
   logic              fetch1_reg, fetch2_reg, fetch_next, load_cur;
   logic              sync1_reg, sync2_reg, prev_reg, tick;
   logic              tx_en_reg, tx_en_next;
   logic [3:0]        txd_reg, txd_next;
   logic              done_reg, done_next, len_err_reg, len_err_next;
   logic              crc_init, crc_en;
   logic [3:0]        crc_nib, data_nib, fcs_nib;
   logic [31:0]       crc, fcs_word;
   logic [11:0]       data_last;
   logic [10:0]       fetch_byte;
   logic              pad_needed;

   assign tick       = sync2_reg & ~prev_reg;
   assign data_nib   = cur_word_reg[{cnt_reg[2:0], 2'b00} +: 4];
   assign fcs_word   = ~crc;
   assign fcs_nib    = fcs_word[{cnt_reg[2:0], 2'b00} +: 4];
   assign data_last  = {len_reg, 1'b0} - 12'd1;
   // First byte of the word after the one about to become current.
   assign fetch_byte = {cnt_reg[11:3] + 9'd2, 2'b00};
   assign pad_needed = (PAD_EN != 0) && (len_reg < 11'(MIN_FRAME));

   eth_crc32 u_crc (
      .mainclk (mainclk),
      .rst     (rst),
      .init    (crc_init),
      .en      (crc_en),
      .nib     (crc_nib),
      .crc     (crc)
   );

   always_ff @(posedge mainclk) begin
      if (rst) begin
         sync1_reg     <= 1'b0;
         sync2_reg     <= 1'b0;
         prev_reg      <= 1'b0;
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         len_reg       <= '0;
         rd_addr_reg   <= '0;
         cur_word_reg  <= '0;
         next_word_reg <= '0;
         fetch1_reg    <= 1'b0;
         fetch2_reg    <= 1'b0;
         tx_en_reg     <= 1'b0;
         txd_reg       <= '0;
         done_reg      <= 1'b0;
         len_err_reg   <= 1'b0;
      end else begin
         sync1_reg   <= eth_tx_clk;
         sync2_reg   <= sync1_reg;
         prev_reg    <= sync2_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         len_reg     <= len_next;
         rd_addr_reg <= rd_addr_next;
         tx_en_reg   <= tx_en_next;
         txd_reg     <= txd_next;
         done_reg    <= done_next;
         len_err_reg <= len_err_next;
         // RAM answers one cycle after the address register updates.
         fetch1_reg  <= fetch_next;
         fetch2_reg  <= fetch1_reg;
         if (fetch2_reg)
            next_word_reg <= rd_data;
         if (load_cur)
            cur_word_reg <= next_word_reg;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      len_next     = len_reg;
      rd_addr_next = rd_addr_reg;
      tx_en_next   = tx_en_reg;
      txd_next     = txd_reg;
      done_next    = 1'b0;
      len_err_next = 1'b0;
      fetch_next   = 1'b0;
      load_cur     = 1'b0;
      crc_init     = 1'b0;
      crc_en       = 1'b0;
      crc_nib      = 4'h0;
      case (state_reg)
         ST_IDLE: begin
            tx_en_next = 1'b0;
            txd_next   = 4'h0;
            if (start && ready) begin
               if (frame_len != 11'd0 && frame_len <= 11'(MAX_FRAME)) begin
                  state_next   = ST_PRE;
                  cnt_next     = '0;
                  len_next     = frame_len;
                  rd_addr_next = base_addr;
                  fetch_next   = 1'b1;
                  crc_init     = 1'b1;
               end else begin
                  len_err_next = 1'b1;
               end
            end
         end
         ST_PRE: if (tick) begin
            tx_en_next = 1'b1;
            txd_next   = PRE_NIB;
            if (cnt_reg == 12'(PRE_LEN - 1)) begin
               state_next = ST_SFD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 12'd1;
            end
         end
         ST_SFD: if (tick) begin
            tx_en_next = 1'b1;
            txd_next   = SFD_NIB;
            state_next = ST_DATA;
            cnt_next   = '0;
            load_cur   = 1'b1;
            if (len_reg > 11'd4) begin
               rd_addr_next = rd_addr_reg + ADDR_ONE;
               fetch_next   = 1'b1;
            end
         end
         ST_DATA: if (tick) begin
            tx_en_next = 1'b1;
            txd_next   = data_nib;
            crc_en     = 1'b1;
            crc_nib    = data_nib;
            cnt_next   = cnt_reg + 12'd1;
            if (cnt_reg == data_last) begin
               if (pad_needed) begin
                  state_next = ST_PAD;
               end else begin
                  state_next = ST_FCS;
                  cnt_next   = '0;
               end
            end else if (cnt_reg[2:0] == 3'd7) begin
               load_cur = 1'b1;
               if (fetch_byte < len_reg) begin
                  rd_addr_next = rd_addr_reg + ADDR_ONE;
                  fetch_next   = 1'b1;
               end
            end
         end
         ST_PAD: if (tick) begin
            tx_en_next = 1'b1;
            txd_next   = 4'h0;
            crc_en     = 1'b1;
            if (cnt_reg == 12'(2 * MIN_FRAME - 1)) begin
               state_next = ST_FCS;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 12'd1;
            end
         end
         ST_FCS: if (tick) begin
            tx_en_next = 1'b1;
            txd_next   = fcs_nib;
            if (cnt_reg == 12'd7) begin
               state_next = ST_IFG;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 12'd1;
            end
         end
         ST_IFG: if (tick) begin
            tx_en_next = 1'b0;
            txd_next   = 4'h0;
            if (cnt_reg == 12'(IFG_NIB - 1)) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 12'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Holding ready low during the done cycle makes it rise one cycle later.
   assign ready     = (state_reg == ST_IDLE) && !done_reg;
   assign done      = done_reg;
   assign len_err   = len_err_reg;
   assign rd_addr   = rd_addr_reg;
   assign eth_tx_en = tx_en_reg;
   assign eth_txd   = txd_reg;
endmodule

// File: tb/tb_eth_mii_tx.sv
// Self-checking bench for eth_mii_tx: two instances (padding off/on) sharing one RAM,
// checked against a byte-level frame/CRC model.
module tb_eth_mii_tx;
   localparam int IFG = 24;

   logic        mainclk, rst, eth_tx_clk;
   logic        start0, start1;
   logic [10:0] frame_len;
   logic [8:0]  base_addr;
   logic        ready0, done0, len_err0, tx_en0, ready1, done1, len_err1, tx_en1;
   logic [8:0]  rd_addr0, rd_addr1;
   logic [31:0] rd_data0, rd_data1;
   logic [3:0]  txd0, txd1;
   logic [31:0] ram [0:511];

   logic        sel;
   logic        mon_en, mon_done, mon_lerr;
   logic [3:0]  mon_txd;

   int          n_vec, n_err;
   int          tick_cnt, last_en_tick, done_cnt, done_tick, lerr_cnt;
   logic [8:0]  prev_addr;
   logic [3:0]  cap_q[$];
   int          en_ticks[$];
   int          addr_q[$];
   logic [3:0]  exp_q[$];

   eth_mii_tx #(.ADDR_W(9), .IFG_NIB(IFG), .PAD_EN(0)) dut0 (
      .mainclk(mainclk), .rst(rst), .eth_tx_clk(eth_tx_clk), .start(start0),
      .frame_len(frame_len), .base_addr(base_addr), .ready(ready0), .done(done0),
      .len_err(len_err0), .rd_addr(rd_addr0), .rd_data(rd_data0),
      .eth_tx_en(tx_en0), .eth_txd(txd0));

   eth_mii_tx #(.ADDR_W(9), .IFG_NIB(IFG), .PAD_EN(1)) dut1 (
      .mainclk(mainclk), .rst(rst), .eth_tx_clk(eth_tx_clk), .start(start1),
      .frame_len(frame_len), .base_addr(base_addr), .ready(ready1), .done(done1),
      .len_err(len_err1), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .eth_tx_en(tx_en1), .eth_txd(txd1));

   initial begin
      mainclk = 0;
      forever #5 mainclk = ~mainclk;
   end
   initial begin
      eth_tx_clk = 0;
      #2;
      forever #20 eth_tx_clk = ~eth_tx_clk;
   end

   always @(posedge mainclk) begin
      rd_data0 <= ram[rd_addr0];
      rd_data1 <= ram[rd_addr1];
   end

   assign mon_en   = sel ? tx_en1 : tx_en0;
   assign mon_txd  = sel ? txd1 : txd0;
   assign mon_done = sel ? done1 : done0;
   assign mon_lerr = sel ? len_err1 : len_err0;

   // Outputs settle about 25 ns after a TX-clock rise, so each rise samples the previous tick.
   always @(posedge eth_tx_clk) begin
      tick_cnt++;
      if (mon_en) begin
         cap_q.push_back(mon_txd);
         en_ticks.push_back(tick_cnt);
         last_en_tick = tick_cnt;
      end
   end

   always @(negedge mainclk) begin
      if (mon_done) begin
         done_cnt++;
         done_tick = tick_cnt;
      end
      if (mon_lerr) lerr_cnt++;
      if (rd_addr0 !== prev_addr) begin
         addr_q.push_back(int'(rd_addr0));
         prev_addr = rd_addr0;
      end
   end

   function automatic logic [7:0] ram_byte(input int base, input int k);
      logic [31:0] w;
      w = ram[(base + k / 4) % 512];
      return w[8 * (k % 4) +: 8];
   endfunction

   // Appends the full expected MII nibble stream of one frame to exp_q.
   task automatic build_expected(input int len, input int base, input bit pad);
      logic [31:0] c;
      logic [7:0]  b;
      int          total;
      c = 32'hFFFFFFFF;
      total = (pad && len < 60) ? 60 : len;
      repeat (15) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      for (int k = 0; k < total; k++) begin
         b = (k < len) ? ram_byte(base, k) : 8'h00;
         exp_q.push_back(b[3:0]);
         exp_q.push_back(b[7:4]);
         c = c ^ {24'd0, b};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 8; k++) exp_q.push_back(c[4 * k +: 4]);
   endtask

   // Index of the first disagreement between captured (from st) and expected; -1 if equal.
   function automatic int first_diff(input int st);
      int n;
      n = cap_q.size() - st;
      if (exp_q.size() < n) n = exp_q.size();
      for (int i = 0; i < n; i++) if (cap_q[st + i] !== exp_q[i]) return i;
      if (cap_q.size() - st != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic send_frame(input bit s, input int len, input int base, output bit to);
      int d0, limit;
      d0 = done_cnt;
      limit = (2 * len + 220) * 5 + 200;
      @(negedge mainclk);
      sel = s;
      frame_len = 11'(len);
      base_addr = 9'(base);
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(negedge mainclk);
      start0 = 1'b0;
      start1 = 1'b0;
      to = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge mainclk);
         if (done_cnt > d0) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      @(negedge mainclk);
      n_vec += 8;
      if (ready0 !== 1'b1)   begin n_err++; $display("FAIL reset_ready0 got %b want 1", ready0); end
      if (done0 !== 1'b0)    begin n_err++; $display("FAIL reset_done0 got %b want 0", done0); end
      if (len_err0 !== 1'b0) begin n_err++; $display("FAIL reset_len_err0 got %b want 0", len_err0); end
      if (tx_en0 !== 1'b0)   begin n_err++; $display("FAIL reset_tx_en0 got %b want 0", tx_en0); end
      if (txd0 !== 4'h0)     begin n_err++; $display("FAIL reset_txd0 got %h want 0", txd0); end
      if (rd_addr0 !== 9'd0) begin n_err++; $display("FAIL reset_rd_addr0 got %0d want 0", rd_addr0); end
      if (ready1 !== 1'b1)   begin n_err++; $display("FAIL reset_ready1 got %b want 1", ready1); end
      if (tx_en1 !== 1'b0)   begin n_err++; $display("FAIL reset_tx_en1 got %b want 0", tx_en1); end
      $display("test_reset: outputs checked");
   endtask

   task automatic test_known_vector();
      int c0, d;
      bit to;
      logic [31:0] fcs;
      ram[9'h10] = 32'h34333231;
      ram[9'h11] = 32'h38373635;
      ram[9'h12] = 32'hA5A50039;
      c0 = cap_q.size();
      exp_q.delete();
      build_expected(9, 'h10, 1'b0);
      send_frame(1'b0, 9, 'h10, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL known_done timeout got no done want done"); end
      n_vec++;
      d = first_diff(c0);
      if (d >= 0) begin n_err++; $display("FAIL known_stream nibble %0d: got %0d nibbles want %0d", d, cap_q.size() - c0, exp_q.size()); end
      fcs = 'x;
      if (cap_q.size() - c0 == 42) for (int k = 0; k < 8; k++) fcs[4 * k +: 4] = cap_q[c0 + 34 + k];
      n_vec++;
      if (fcs !== 32'hCBF43926) begin n_err++; $display("FAIL known_fcs got %h want cbf43926", fcs); end
      n_vec++;
      if (done_tick - last_en_tick != IFG - 1) begin n_err++; $display("FAIL known_ifg got gap %0d want %0d", done_tick - last_en_tick, IFG - 1); end
      $display("test_known_vector: len=9 nibbles=%0d fcs=%h", cap_q.size() - c0, fcs);
   endtask

   task automatic test_pad();
      int c0, d, nz, base;
      bit to;
      base = $urandom_range(0, 511);
      c0 = cap_q.size();
      exp_q.delete();
      build_expected(14, base, 1'b1);
      send_frame(1'b1, 14, base, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL pad_done timeout got no done want done"); end
      n_vec++;
      if (cap_q.size() - c0 != 144) begin n_err++; $display("FAIL pad_len got %0d nibbles want 144", cap_q.size() - c0); end
      nz = 0;
      if (cap_q.size() - c0 == 144) for (int i = 44; i < 136; i++) if (cap_q[c0 + i] != 4'h0) nz++;
      n_vec++;
      if (nz != 0) begin n_err++; $display("FAIL pad_zero got %0d nonzero pad nibbles want 0", nz); end
      n_vec++;
      d = first_diff(c0);
      if (d >= 0) begin n_err++; $display("FAIL pad_stream nibble %0d: got %0d nibbles want %0d", d, cap_q.size() - c0, exp_q.size()); end
      $display("test_pad: len=14 base=%0d nibbles=%0d", base, cap_q.size() - c0);
   endtask

   task automatic test_random();
      int c0, d, len, base;
      bit s, to;
      for (int i = 0; i < 5; i++) begin
         s = i[0];
         len = (i == 4) ? 1514 : int'($urandom_range(1, 90));
         base = $urandom_range(0, 511);
         c0 = cap_q.size();
         exp_q.delete();
         build_expected(len, base, s);
         send_frame(s, len, base, to);
         n_vec++;
         if (to) begin n_err++; $display("FAIL rand_done[%0d] timeout got no done want done", i); end
         n_vec++;
         d = first_diff(c0);
         if (d >= 0) begin n_err++; $display("FAIL rand_stream[%0d] nibble %0d: got %0d nibbles want %0d", i, d, cap_q.size() - c0, exp_q.size()); end
         n_vec++;
         if (done_tick - last_en_tick != IFG - 1) begin n_err++; $display("FAIL rand_ifg[%0d] got gap %0d want %0d", i, done_tick - last_en_tick, IFG - 1); end
         $display("test_random: dut%0d len=%0d base=%0d nibbles=%0d", s, len, base, cap_q.size() - c0);
      end
   endtask

   task automatic test_len_err();
      int c0, l0, len;
      for (int i = 0; i < 2; i++) begin
         len = (i == 0) ? 0 : 1515;
         c0 = cap_q.size();
         l0 = lerr_cnt;
         @(negedge mainclk);
         sel = 1'b0;
         frame_len = 11'(len);
         start0 = 1'b1;
         @(negedge mainclk);
         start0 = 1'b0;
         repeat (60) @(negedge mainclk);
         n_vec += 3;
         if (lerr_cnt != l0 + 1) begin n_err++; $display("FAIL len_err_pulse[%0d] got %0d pulses want 1", len, lerr_cnt - l0); end
         if (cap_q.size() != c0) begin n_err++; $display("FAIL len_err_tx[%0d] got %0d nibbles want 0", len, cap_q.size() - c0); end
         if (ready0 !== 1'b1) begin n_err++; $display("FAIL len_err_ready[%0d] got %b want 1", len, ready0); end
         $display("test_len_err: len=%0d pulses=%0d", len, lerr_cnt - l0);
      end
   endtask

   task automatic test_back_to_back();
      int c0, e0, d0, d, phase, gap;
      bit to;
      c0 = cap_q.size();
      e0 = en_ticks.size();
      d0 = done_cnt;
      exp_q.delete();
      build_expected(20, 'h80, 1'b0);
      build_expected(20, 'h80, 1'b0);
      @(negedge mainclk);
      sel = 1'b0;
      frame_len = 11'd20;
      base_addr = 9'h80;
      start0 = 1'b1;
      phase = 0;
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge mainclk);
         if (phase == 0 && !ready0) phase = 1;
         else if (phase == 1 && ready0) phase = 2;
         else if (phase == 2 && !ready0) begin to = 1'b0; break; end
      end
      start0 = 1'b0;
      for (int i = 0; i < 3000 && done_cnt < d0 + 2; i++) @(negedge mainclk);
      n_vec++;
      if (to || done_cnt != d0 + 2) begin n_err++; $display("FAIL b2b_done got %0d frames want 2", done_cnt - d0); end
      gap = 0;
      for (int i = e0 + 1; i < en_ticks.size(); i++) if (en_ticks[i] - en_ticks[i - 1] > gap) gap = en_ticks[i] - en_ticks[i - 1];
      n_vec++;
      if (gap < IFG + 1) begin n_err++; $display("FAIL b2b_gap got %0d want >= %0d", gap, IFG + 1); end
      n_vec++;
      d = first_diff(c0);
      if (d >= 0) begin n_err++; $display("FAIL b2b_stream nibble %0d: got %0d nibbles want %0d", d, cap_q.size() - c0, exp_q.size()); end
      $display("test_back_to_back: frames=%0d gap=%0d", done_cnt - d0, gap);
   endtask

   task automatic test_reset_mid();
      int c0, d0, d, len;
      bit to;
      c0 = cap_q.size();
      d0 = done_cnt;
      @(negedge mainclk);
      sel = 1'b0;
      frame_len = 11'd40;
      base_addr = 9'h20;
      start0 = 1'b1;
      @(negedge mainclk);
      start0 = 1'b0;
      for (int i = 0; i < 2000 && cap_q.size() < c0 + 56; i++) @(negedge mainclk);
      @(negedge mainclk);
      rst = 1'b1;
      @(posedge mainclk);
      #1;
      n_vec += 2;
      if (tx_en0 !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_en got %b want 0", tx_en0); end
      if (ready0 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", ready0); end
      @(negedge mainclk);
      rst = 1'b0;
      c0 = cap_q.size();
      repeat (200) @(negedge mainclk);
      n_vec++;
      if (cap_q.size() != c0 || done_cnt != d0) begin n_err++; $display("FAIL rstmid_tail got %0d nibbles %0d done want 0 0", cap_q.size() - c0, done_cnt - d0); end
      len = $urandom_range(1, 70);
      c0 = cap_q.size();
      exp_q.delete();
      build_expected(len, 'h40, 1'b0);
      send_frame(1'b0, len, 'h40, to);
      n_vec++;
      d = first_diff(c0);
      if (to || d >= 0) begin n_err++; $display("FAIL rstmid_resend nibble %0d: got %0d nibbles want %0d", d, cap_q.size() - c0, exp_q.size()); end
      $display("test_reset_mid: resend len=%0d nibbles=%0d", len, cap_q.size() - c0);
   endtask

   task automatic test_wrap();
      int c0, a0, d;
      bit to;
      @(negedge mainclk);
      rst = 1'b1;
      repeat (2) @(negedge mainclk);
      rst = 1'b0;
      @(negedge mainclk);
      a0 = addr_q.size();
      c0 = cap_q.size();
      exp_q.delete();
      build_expected(16, 510, 1'b0);
      send_frame(1'b0, 16, 510, to);
      n_vec++;
      if (addr_q.size() - a0 != 4 || addr_q[a0] != 510 || addr_q[a0 + 1] != 511 || addr_q[a0 + 2] != 0 || addr_q[a0 + 3] != 1) begin
         n_err++;
         $display("FAIL wrap_addr got %0d addresses starting %0d want 510,511,0,1", addr_q.size() - a0, (addr_q.size() > a0) ? addr_q[a0] : -1);
      end
      n_vec++;
      d = first_diff(c0);
      if (to || d >= 0) begin n_err++; $display("FAIL wrap_stream nibble %0d: got %0d nibbles want %0d", d, cap_q.size() - c0, exp_q.size()); end
      $display("test_wrap: base=510 len=16 addresses=%0d", addr_q.size() - a0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      tick_cnt = 0; last_en_tick = 0; done_cnt = 0; done_tick = 0; lerr_cnt = 0;
      prev_addr = 9'd0;
      sel = 1'b0;
      start0 = 1'b0; start1 = 1'b0;
      frame_len = '0; base_addr = '0;
      for (int i = 0; i < 512; i++) ram[i] = $urandom;
      rst = 1'b1;
      repeat (5) @(negedge mainclk);
      rst = 1'b0;
      test_reset();
      test_known_vector();
      test_pad();
      test_random();
      test_len_err();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/eth_mii_tx.md
ETH_MII_TX -- requirements
Module: eth_mii_tx

Interface
REQ-001 Parameter ADDR_W, default 9, frame RAM word-address width.
REQ-002 Parameter IFG_NIB, default 24, inter-frame gap in tx_clk ticks (96 bit times).
REQ-003 Parameter PAD_EN, default 1, zero-pad frames shorter than 60 bytes to 60 bytes before FCS.
REQ-004 Reset rst, synchronous, active-high; clock mainclk.
REQ-005 mainclk  in  1  100 MHz system clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 eth_tx_clk  in  1  25 MHz PHY TX clock, asynchronous to mainclk.
REQ-008 start  in  1  request to send one frame; accepted when start & ready.
REQ-009 frame_len  in  11  frame length in bytes, excluding preamble/SFD/FCS; sampled on accept.
REQ-010 base_addr  in  ADDR_W  RAM word address of byte 0; sampled on accept.
REQ-011 ready  out  1  high only in IDLE.
REQ-012 done  out  1  one-cycle pulse when IFG completes.
REQ-013 len_err  out  1  one-cycle pulse when start is rejected for length.
REQ-014 rd_addr  out  ADDR_W  RAM read address.
REQ-015 rd_data  in  32  RAM read data, valid 1 mainclk after rd_addr.
REQ-016 eth_tx_en  out  1  MII transmit enable.
REQ-017 eth_txd  out  4  MII transmit nibble.

Function
REQ-018 eth_tx_clk SHALL pass a 2-flop synchronizer plus edge register; a detected rising edge is a "tick"; eth_tx_en/eth_txd SHALL change only on the mainclk cycle following a tick.
REQ-019 States SHALL be IDLE, PRE, SFD, DATA, PAD, FCS, IFG; each non-IDLE state advances one nibble per tick.
REQ-020 IDLE: accept when start & ready & 1<=frame_len<=1514, then go to PRE; otherwise, when start & ready, pulse len_err and remain in IDLE.
REQ-021 PRE SHALL emit 15 nibbles 0x5; SFD SHALL emit one nibble 0xD; eth_tx_en=1 from first PRE nibble through last FCS nibble.
REQ-022 DATA SHALL emit frame_len bytes; byte k = word (base_addr + k/4), bits [8*(k%4)+7 : 8*(k%4)]; low nibble first.
REQ-023 The next RAM word SHALL be prefetched so it is registered before its first nibble is needed; rd_addr wraps modulo 2^ADDR_W.
REQ-024 PAD (only if PAD_EN and frame_len<60) SHALL emit 0x0 nibbles until 60 bytes total have been sent.
REQ-025 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) SHALL cover DATA and PAD nibbles only; it is updated one nibble per tick.
REQ-026 FCS SHALL emit the complement of the CRC as 8 nibbles, least-significant nibble first.
REQ-027 IFG SHALL hold eth_tx_en=0 and eth_txd=0 for IFG_NIB ticks, then pulse done and enter IDLE; ready rises on the cycle after done.
REQ-028 start while not ready SHALL be ignored with no side effects.
REQ-029 In IDLE and IFG, eth_txd=0 and eth_tx_en=0.

Reset
REQ-030 On rst: state=IDLE, ready=1, done=0, len_err=0, eth_tx_en=0, eth_txd=0, rd_addr=0, CRC=0xFFFFFFFF, synchronizer flops=0.
REQ-031 rst asserted mid-frame SHALL drop eth_tx_en on the next mainclk edge; no FCS or IFG is emitted.

Structure
REQ-032 Package eth_pkg SHALL hold the state enum, PRE_NIB=4'h5, SFD_NIB=4'hD, CRC_POLY, CRC_INIT, and MIN_FRAME=60.
REQ-033 Sub-module eth_crc32 SHALL hold the registered CRC with init/enable/nibble inputs and a crc output; eth_mii_tx instantiates one.

Verification
REQ-034 PAD_EN=0, frame_len=9, RAM bytes "123456789" -> 15x5, D, nibbles 1,3,2,3,...,9,3, then FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926); then done after 24 ticks.
REQ-035 PAD_EN=1, frame_len=14 -> exactly 120 DATA+PAD nibbles; the last 92 are 0; FCS is checked against a reference model.
REQ-036 frame_len=0 and frame_len=1515 -> len_err pulse, eth_tx_en stays 0, ready stays 1.
REQ-037 Two back-to-back starts (second held high through the first frame) -> second frame begins no earlier than IFG_NIB ticks after the first FCS nibble.
REQ-038 rst asserted at DATA byte 20 -> eth_tx_en=0 on the next mainclk edge, state IDLE, a new frame is then sent correctly.
REQ-039 base_addr=2^ADDR_W-2, frame_len=16 -> rd_addr sequence 510, 511, 0, 1; payload nibbles match RAM.
